// File: rtl/multiplier_pipe.sv
// multiplier_pipe: four-stage pipelined integer multiplier with limb-wise
// partial products, optional two's-complement operands and valid/ready flow
// control. The whole pipeline advances together and stalls together.
module multiplier_pipe #(
    parameter int WIDTH = 24,
    parameter int LIMB  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int NL = WIDTH / LIMB;   // limbs per operand
    localparam int NP = NL * NL;        // partial products
    localparam int PW = 2 * WIDTH;      // product width
    localparam int LW = 2 * LIMB;       // partial product width

    // Global advance enable: the last stage is free or being drained.
    logic adv;

    // Stage valid bits.
    logic v1, v2, v3, v4;

    // Stage data registers.
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic             neg1_q, neg2_q, neg3_q;
    logic [LW-1:0]    pp_q [NP];
    logic [PW-1:0]    sum_q;
    logic [PW-1:0]    res_q;

    // Next-state values for each stage.
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic             neg_d;
    logic [LW-1:0]    pp_d [NP];
    logic [PW-1:0]    sum_d;
    logic [PW-1:0]    res_d;

    assign adv       = !v4 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v4;
    assign result    = res_q;

    // S1 input: operand magnitudes and sign of the final product.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        mag_a_d = num1;
        mag_b_d = num2;
        neg_d   = 1'b0;
        if (is_signed) begin
            // The most negative value negates to itself, which read as
            // unsigned is exactly its magnitude 2^(WIDTH-1).
            if (num1[WIDTH-1]) mag_a_d = ~num1 + WIDTH'(1);
            if (num2[WIDTH-1]) mag_b_d = ~num2 + WIDTH'(1);
            neg_d = num1[WIDTH-1] ^ num2[WIDTH-1];
        end
    end

    // S2 input: every limb of A times every limb of B, all in parallel.
    always_comb begin
        pp_d = '{default: '0};
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < NL; j++) begin
                pp_d[i*NL+j] = LW'(mag_a_q[i*LIMB +: LIMB]) * LW'(mag_b_q[j*LIMB +: LIMB]);
            end
        end
    end

    // S3 input: weighted sum of the partial products at full product width.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < NL; j++) begin
                // NOTE: blocking assignment here is intentional: it chains the accumulation within one evaluation of combinational logic.
                sum_d = sum_d + (PW'(pp_q[i*NL+j]) << ((i + j) * LIMB));
            end
        end
    end

    // S4 input: reapply the sign; negating zero wraps back to zero.
    always_comb begin
        res_d = sum_q;
        if (neg3_q) res_d = ~sum_q + PW'(1);
    end

    // Valid bits: shift as one on advance, hold as one on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
        end
    end

    // Data registers: load on advance regardless of validity; bubbles carry don't-care data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            neg3_q  <= 1'b0;
            // NOTE: the partial-product array is cleared element by element so reset leaves every data register at a defined zero.
            for (int k = 0; k < NP; k++) pp_q[k] <= '0;
            sum_q   <= '0;
            res_q   <= '0;
        end else if (adv) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg1_q  <= neg_d;
            pp_q    <= pp_d;
            neg2_q  <= neg1_q;
            sum_q   <= sum_d;
            neg3_q  <= neg2_q;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_multiplier_pipe.sv
// tb_multiplier_pipe: directed and randomized checks of multiplier_pipe
// against an integer-arithmetic reference model and a FIFO scoreboard.
module tb_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;

    // 24/12 instance
    logic        iv, ordy, sg;
    logic [23:0] n1, n2;
    logic        ir, ov;
    logic [47:0] res;
    logic [47:0] q24 [$];

    // 32/8 instance
    logic        iv32, sg32, ir32, ov32;
    logic [31:0] n1_32, n2_32;
    logic [63:0] res32;
    logic [63:0] q32 [$];

    // 16/16 instance
    logic        iv16, sg16, ir16, ov16;
    logic [15:0] n1_16, n2_16;
    logic [31:0] res16;
    logic [31:0] q16 [$];

    always #5 clk = ~clk;

    multiplier_pipe #(.WIDTH(24), .LIMB(12)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .num1(n1), .num2(n2),
        .is_signed(sg), .out_valid(ov), .out_ready(ordy), .result(res)
    );

    multiplier_pipe #(.WIDTH(32), .LIMB(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .num1(n1_32), .num2(n2_32),
        .is_signed(sg32), .out_valid(ov32), .out_ready(1'b1), .result(res32)
    );

    multiplier_pipe #(.WIDTH(16), .LIMB(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .num1(n1_16), .num2(n2_16),
        .is_signed(sg16), .out_valid(ov16), .out_ready(1'b1), .result(res16)
    );

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input bit s);
        longint      xs, ys;
        logic [63:0] p, mask;
        xs = longint'(x);
        ys = longint'(y);
        if (s && x[w-1]) xs = xs - (longint'(1) << w);
        if (s && y[w-1]) ys = ys - (longint'(1) << w);
        p    = 64'(xs * ys);
        mask = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return p & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle on the 24-bit instance with scoreboard bookkeeping.
    task automatic cycle(input bit v, input logic [23:0] a, input logic [23:0] b,
                         input bit s, input bit rdy, input logic [47:0] exp, output bit took);
        bit          held;
        logic [47:0] held_res;
        iv = v; n1 = a; n2 = b; sg = s; ordy = rdy;
        #1;
        check("in_ready", ir, !ov || ordy);
        if (ov && ordy) begin
            if (q24.size() == 0) check("spurious_out", ov, 0);
            else                 check("result", res, q24.pop_front());
        end
        took = v && ir;
        if (took) q24.push_back(exp);
        held     = ov && !ordy;
        held_res = res;
        tick();
        if (held) begin
            check("stall_valid", ov, 1);
            check("stall_result", res, held_res);
        end
    endtask

    task automatic drain();
        int n = 0;
        bit t;
        while (q24.size() > 0 && n < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, t);
            n++;
        end
        check("drain_empty", q24.size(), 0);
    endtask

    // Single isolated transaction: out_valid must rise exactly 3 cycles after accept.
    task automatic latency_test(input logic [23:0] a, input logic [23:0] b, input bit s,
                                input logic [47:0] exp);
        iv = 1'b1; n1 = a; n2 = b; sg = s; ordy = 1'b1;
        #1;
        check("lat_ready", ir, 1);
        tick();
        iv = 1'b0;
        check("lat_c0_valid", ov, 0);
        tick();
        check("lat_c1_valid", ov, 0);
        tick();
        check("lat_c2_valid", ov, 0);
        tick();
        check("lat_c3_valid", ov, 1);
        check("lat_c3_result", res, exp);
        tick();
        check("lat_c4_valid", ov, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          t;
        int          sent;
        int          budget;
        logic [23:0] a, b;
        bit          s;

        rst = 1'b1; iv = 1'b0; ordy = 1'b1; sg = 1'b0; n1 = '0; n2 = '0;
        iv32 = 1'b0; sg32 = 1'b0; n1_32 = '0; n2_32 = '0;
        iv16 = 1'b0; sg16 = 1'b0; n1_16 = '0; n2_16 = '0;
        #12;
        check("rst_in_ready", ir, 1);
        check("rst_out_valid", ov, 0);
        check("rst_result", res, 0);
        tick();
        rst = 1'b0;

        // Unsigned corner with exact latency.
        latency_test(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001);

        // Back-to-back mixed modes and most-negative corners.
        cycle(1'b1, 24'hFFFFFF, 24'h000002, 1'b1, 1'b1, 48'hFFFFFFFFFFFE, t);
        cycle(1'b1, 24'hFFFFFF, 24'h000002, 1'b0, 1'b1, 48'h000001FFFFFE, t);
        cycle(1'b1, 24'h800000, 24'h800000, 1'b1, 1'b1, 48'h400000000000, t);
        cycle(1'b1, 24'h800000, 24'h000001, 1'b1, 1'b1, 48'hFFFFFF800000, t);
        cycle(1'b1, 24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 48'h000000000000, t);
        drain();

        // Streaming with random back-pressure.
        sent = 0; budget = 0;
        a = 24'($urandom); b = 24'($urandom); s = 1'($urandom_range(0, 1));
        while (sent < 20 && budget < 300) begin
            cycle(1'b1, a, b, s, 1'($urandom_range(0, 1)),
                  48'(ref_mul(24, {40'b0, a}, {40'b0, b}, s)), t);
            budget++;
            if (t) begin
                sent++;
                a = 24'($urandom); b = 24'($urandom); s = 1'($urandom_range(0, 1));
            end
        end
        check("stream_sent", sent, 20);
        drain();

        // Reset mid-flight.
        for (int k = 0; k < 3; k++) begin
            a = 24'($urandom); b = 24'($urandom);
            cycle(1'b1, a, b, 1'b0, 1'b1, 48'(ref_mul(24, {40'b0, a}, {40'b0, b}, 1'b0)), t);
        end
        iv = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", ov, 0);
        check("midrst_result", res, 0);
        check("midrst_in_ready", ir, 1);
        tick();
        rst = 1'b0;
        q24.delete();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, t);
            check("post_rst_idle", ov, 0);
        end
        latency_test(24'h123456, 24'h000ABC, 1'b0,
                     48'(ref_mul(24, 64'h123456, 64'h000ABC, 1'b0)));

        // Parameter sweep on the 32/8 and 16/16 instances.
        for (int k = 0; k < 40; k++) begin
            iv32  = (k < 32);
            n1_32 = $urandom; n2_32 = $urandom; sg32 = 1'($urandom_range(0, 1));
            iv16  = (k < 32);
            n1_16 = 16'($urandom); n2_16 = 16'($urandom); sg16 = 1'($urandom_range(0, 1));
            if (k == 0) begin
                n1_32 = 32'h80000000; n2_32 = 32'h80000000; sg32 = 1'b1;
                n1_16 = 16'h8000;     n2_16 = 16'h0001;     sg16 = 1'b1;
            end
            if (k == 1) begin
                n1_32 = '1; n2_32 = '1; sg32 = 1'b0;
                n1_16 = '1; n2_16 = '1; sg16 = 1'b0;
            end
            #1;
            if (ov32) begin
                if (q32.size() == 0) check("w32_spurious", ov32, 0);
                else                 check("w32_result", res32, q32.pop_front());
            end
            if (ov16) begin
                if (q16.size() == 0) check("w16_spurious", ov16, 0);
                else                 check("w16_result", res16, q16.pop_front());
            end
            if (iv32 && ir32) q32.push_back(ref_mul(32, {32'b0, n1_32}, {32'b0, n2_32}, sg32));
            if (iv16 && ir16) q16.push_back(32'(ref_mul(16, {48'b0, n1_16}, {48'b0, n2_16}, sg16)));
            tick();
        end
        check("w32_drain", q32.size(), 0);
        check("w16_drain", q16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_pipe.md
# multiplier_pipe

Parametrised, fully pipelined integer multiplier for the arithmetic datapath. It splits each WIDTH-bit operand into LIMB-bit limbs and forms all limb partial products in parallel. It then sums them and applies an optional two's-complement sign correction. One product is accepted per cycle behind a valid/ready handshake, and the pipeline stalls as a whole when the consumer back-pressures. It is the drop-in successor to the fixed 24-bit, 12-bit-limb multiplier, adding width/limb parameters, signed mode, flow control and reset-defined outputs.

## Interface
- WIDTH, 24, operand width in bits; must be an integer multiple of LIMB.
- LIMB, 12, limb width in bits; NL = WIDTH/LIMB limbs per operand, NL*NL partial products.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high: clears all pipeline state immediately.
- in_valid  input  1  operands on num1/num2/is_signed are valid this cycle.
- in_ready  output  1  pipeline can accept; transfer occurs when in_valid && in_ready.
- num1  input  WIDTH  multiplicand.
- num2  input  WIDTH  multiplier.
- is_signed  input  1  1 = both operands two's complement; 0 = both unsigned; sampled with the operands.
- out_valid  output  1  result holds a completed product.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid && out_ready.
- result  output  2*WIDTH  product.

## Operation
- Four stages, each with a valid bit v1..v4 and a data register. There is one global advance enable: adv = !v4 || out_ready.
- in_ready = adv (combinational). On adv, every stage loads from its predecessor; v1 loads (in_valid && in_ready). With !adv, all stages hold.
- S1: register the operand magnitudes and the result sign.
  - Signed mode: mag = x[WIDTH-1] ? -x : x, in WIDTH-bit unsigned. -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - neg = is_signed && (num1[MSB] ^ num2[MSB]).
  - Unsigned mode: mag = x, neg = 0.
- S2: register all NL*NL partial products p[i][j] = magA limb i * magB limb j. Each is 2*LIMB bits.
- S3: register sum = Σ p[i][j] << ((i+j)*LIMB), computed at 2*WIDTH bits. Magnitude products never exceed 2^(2*WIDTH-2) (signed) or (2^WIDTH-1)^2 (unsigned), so the sum cannot overflow.
- S4: result = neg ? -sum : sum, modulo 2^(2*WIDTH). A zero product with neg=1 yields 0.
- Bubbles (v=0) propagate through the pipeline. Their data registers may update but are don't-care. result is only meaningful when out_valid=1.
- While out_valid && !out_ready, result and out_valid must stay stable until accepted.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, result = 0.
  - v1..v4 = 0; all data registers = 0.
- Reset takes effect asynchronously, and clears the pipeline when asserted mid-operation: all in-flight products are discarded and none appear after release. The first accept is possible on the first rising edge after rst deasserts.
- Latency: an operand pair accepted at edge N produces out_valid=1 with its result after edge N+3, i.e. visible in cycle N+3. This holds with no stalls.
- Throughput: 1 product/cycle when out_ready=1 continuously.
- Stall: out_ready=0 with v4=1 drops in_ready the same cycle. No data is lost or duplicated, and ordering is strictly FIFO.
- Simultaneous output accept and input accept in one cycle is legal and required for full throughput.
- is_signed is per transaction; mixed-mode back-to-back operands must each get their own mode.

## Test plan
- Unsigned corner, WIDTH=24: num1 = num2 = 0xFFFFFF, is_signed=0 -> result 0xFFFFFE000001 with out_valid exactly 3 cycles after accept.
- Signed mixed sign: 0xFFFFFF (-1) × 0x000002, is_signed=1 -> 0xFFFFFFFFFFFE. The same operands with is_signed=0 -> 0x000001FFFFFE. Send both back-to-back; both results come out in order.
- Most-negative: 0x800000 × 0x800000 signed -> 0x400000000000. 0x800000 × 0x000001 signed -> 0xFFFFFF800000.
- Streaming with back-pressure: feed 20 random pairs with in_valid=1 and toggle out_ready randomly. Required response: every result matches the reference model, order is preserved, result is stable while stalled, and in_ready == (!out_valid || out_ready).
- Reset mid-flight: accept 3 pairs, then assert rst for 1 cycle before any completes. out_valid drops to 0 and result reads 0 immediately. No stale result appears afterward, and a new pair accepted post-reset completes with correct latency.
- Parameter sweep: WIDTH=32/LIMB=8 and WIDTH=16/LIMB=16, random signed and unsigned operands -> results bit-exact against a 2*WIDTH-bit reference product.
